// File: rtl/alu_share_arbiter.sv
// Two-requester front end for the shared calculator ALU: round-robin grant with
// optional ownership lock, fixed-latency operand hold, registered result and ack.
module alu_share_arbiter #(
    parameter int                   DATA_W   = 32,
    parameter int                   CMD_W    = 3,
    parameter int                   ALU_LAT  = 1,
    parameter logic [CMD_W-1:0]     IDLE_CMD = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [CMD_W-1:0]  cmd0,
    input  logic              lock0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic [CMD_W-1:0]  cmd1,
    input  logic              lock1,
    output logic              ack1,
    output logic [DATA_W-1:0] res,
    output logic              busy,
    output logic [DATA_W-1:0] al_A,
    output logic [DATA_W-1:0] al_B,
    output logic [CMD_W-1:0]  al_cmd,
    input  logic [DATA_W-1:0] al_C
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       grantee;
    logic       last;
    logic       owned;
    logic       owner;

    logic       eff_own;
    logic       gnt_vld;
    logic       gnt_sel;

    // An owner whose lock has dropped is released and normal arbitration
    // applies in that same IDLE cycle.
    always_comb begin
        eff_own = owned && (owner ? lock1 : lock0);
        gnt_vld = 1'b0;
        gnt_sel = 1'b0;
        if (eff_own) begin
            gnt_vld = owner ? req1 : req0;
            gnt_sel = owner;
        end else if (req0 && req1) begin
            gnt_vld = 1'b1;
            gnt_sel = ~last;
        end else if (req0) begin
            gnt_vld = 1'b1;
            gnt_sel = 1'b0;
        end else if (req1) begin
            gnt_vld = 1'b1;
            gnt_sel = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            grantee <= 1'b0;
            last    <= 1'b1;
            owned   <= 1'b0;
            owner   <= 1'b0;
            al_A    <= '0;
            al_B    <= '0;
            al_cmd  <= IDLE_CMD;
            res     <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    owned <= eff_own;
                    if (gnt_vld) begin
                        al_A    <= gnt_sel ? a1 : a0;
                        al_B    <= gnt_sel ? b1 : b0;
                        al_cmd  <= gnt_sel ? cmd1 : cmd0;
                        grantee <= gnt_sel;
                        last    <= gnt_sel;
                        cnt     <= CNT_INIT;
                        busy    <= 1'b1;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt == 4'd0) begin
                        res    <= al_C;
                        ack0   <= ~grantee;
                        ack1   <= grantee;
                        al_A   <= '0;
                        al_B   <= '0;
                        al_cmd <= IDLE_CMD;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    owned <= grantee ? lock1 : lock0;
                    owner <= grantee;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboarded bench: instance 0 runs ALU_LAT=1, instance 1 runs ALU_LAT=3,
// each driving a small behavioural ALU (1 add, 2 sub, 3 div, 4 mod).
module tb_alu_share_arbiter;
    localparam int DW = 32;
    localparam int CW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    rst, req0, req1, lock0, lock1, ack0, ack1, busy;
    logic [DW-1:0] a0[2], b0[2], a1[2], b1[2], res[2], al_A[2], al_B[2], al_C[2];
    logic [CW-1:0] cmd0[2], cmd1[2], al_cmd[2];

    int n_run  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic          who;
        logic [DW-1:0] val;
    } exp_t;
    exp_t q0[$], q1[$];

    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [CW-1:0] c);
        case (c)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return (b != 0) ? a / b : '0;
            3'd4:    return (b != 0) ? a % b : '0;
            default: return '0;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_share_arbiter #(.DATA_W(DW), .CMD_W(CW), .ALU_LAT(g == 0 ? 1 : 3), .IDLE_CMD(3'd0)) u_dut (
            .Clock(clk), .Reset(rst[g]),
            .req0(req0[g]), .a0(a0[g]), .b0(b0[g]), .cmd0(cmd0[g]), .lock0(lock0[g]), .ack0(ack0[g]),
            .req1(req1[g]), .a1(a1[g]), .b1(b1[g]), .cmd1(cmd1[g]), .lock1(lock1[g]), .ack1(ack1[g]),
            .res(res[g]), .busy(busy[g]), .al_A(al_A[g]), .al_B(al_B[g]), .al_cmd(al_cmd[g]),
            .al_C(al_C[g])
        );
        assign al_C[g] = alu_f(al_A[g], al_B[g], al_cmd[g]);
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int g, input logic who, input logic [DW-1:0] v);
        exp_t e;
        e.who = who;
        e.val = v;
        if (g == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input int g, input logic who, input int budget, output int n);
        n = 0;
        while (!(who ? ack1[g] : ack0[g]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(who ? ack1[g] : ack0[g])) begin
            n_run++;
            n_fail++;
            $display("FAIL timeout_ack%0d_inst%0d: no ack within %0d cycles", who, g, budget);
        end
    endtask

    // Monitor: every ack pops one expected response.
    logic [1:0] p_ack0 = '0, p_ack1 = '0;

    task automatic mon(input int g);
        exp_t e;
        int   sz;
        if (ack0[g] || ack1[g]) begin
            chk($sformatf("ack_exclusive_inst%0d", g), DW'(ack0[g] & ack1[g]), '0);
            chk($sformatf("ack_one_cycle_inst%0d", g),
                DW'((ack0[g] & p_ack0[g]) | (ack1[g] & p_ack1[g])), '0);
            sz = (g == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL sb_unexpected_inst%0d: ack from requester %0d with nothing pending", g, ack1[g]);
            end else begin
                if (g == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("sb_grantee_inst%0d", g), DW'(ack1[g]), DW'(e.who));
                chk($sformatf("sb_res_inst%0d", g), res[g], e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) mon(g);
        p_ack0 <= ack0;
        p_ack1 <= ack1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, k1;
        rst = 2'b11;
        req0 = '0; req1 = '0; lock0 = '0; lock1 = '0;
        for (int g = 0; g < 2; g++) begin
            a0[g] = '0; b0[g] = '0; a1[g] = '0; b1[g] = '0; cmd0[g] = '0; cmd1[g] = '0;
        end
        cyc(3);
        for (int g = 0; g < 2; g++) begin
            chk("rst_ack0", DW'(ack0[g]), '0);
            chk("rst_ack1", DW'(ack1[g]), '0);
            chk("rst_busy", DW'(busy[g]), '0);
            chk("rst_res", res[g], '0);
            chk("rst_al_A", al_A[g], '0);
            chk("rst_al_cmd", DW'(al_cmd[g]), '0);
        end
        rst = 2'b00;
        cyc(1);

        // Single op, LAT=1: 5+7.
        a0[0] = 5; b0[0] = 7; cmd0[0] = 1; req0[0] = 1'b1;
        push(0, 1'b0, 12);
        cyc(1);
        chk("t1_al_A_c1", al_A[0], 5);
        chk("t1_al_B_c1", al_B[0], 7);
        chk("t1_al_cmd_c1", DW'(al_cmd[0]), 1);
        chk("t1_busy_c1", DW'(busy[0]), 1);
        cyc(1);
        chk("t1_ack0_c2", DW'(ack0[0]), 1);
        chk("t1_al_cmd_idle_c2", DW'(al_cmd[0]), 0);
        chk("t1_al_A_clr_c2", al_A[0], 0);
        req0[0] = 1'b0;
        cyc(1);
        chk("t1_busy_c3", DW'(busy[0]), 0);
        chk("t1_ack0_c3", DW'(ack0[0]), 0);
        cyc(1);

        // Both held: last grant was 0, so order is 1,0,1,0 at one op per 3 cycles.
        a0[0] = 10;  b0[0] = 3;  cmd0[0] = 2;
        a1[0] = 100; b1[0] = 10; cmd1[0] = 3;
        req0[0] = 1'b1; req1[0] = 1'b1;
        push(0, 1'b1, 10); push(0, 1'b0, 7); push(0, 1'b1, 10); push(0, 1'b0, 7);
        n = 0; k = 0;
        while (k < 4 && n < 60) begin
            cyc(1); n++;
            if (ack0[0] || ack1[0]) k++;
        end
        req0[0] = 1'b0; req1[0] = 1'b0;
        chk("t2_ack_count", k, 4);
        chk("t2_fourth_ack_cycle", n, 11);
        cyc(1);

        // Lock: requester 1 keeps ownership for three ops while requester 0 waits.
        a1[0] = 1; b1[0] = 2; cmd1[0] = 1; lock1[0] = 1'b1; req1[0] = 1'b1;
        a0[0] = 50; b0[0] = 7; cmd0[0] = 4; req0[0] = 1'b1;
        push(0, 1'b1, 3); push(0, 1'b1, 7); push(0, 1'b1, 11); push(0, 1'b0, 1);
        n = 0; k1 = 0;
        while (n < 60) begin
            cyc(1); n++;
            if (ack0[0]) break;
            if (ack1[0]) begin
                k1++;
                if (k1 == 1) begin a1[0] = 3; b1[0] = 4; end
                if (k1 == 2) begin a1[0] = 5; b1[0] = 6; end
                if (k1 == 3) begin req1[0] = 1'b0; lock1[0] = 1'b0; end
            end
        end
        req0[0] = 1'b0;
        chk("t4_ack1_before_ack0", k1, 3);
        chk("t4_ack0_cycle", n, 11);
        cyc(1);

        // LAT=3: operand change after grant must not reach the ALU.
        a1[1] = 20; b1[1] = 22; cmd1[1] = 1; req1[1] = 1'b1;
        push(1, 1'b1, 42);
        cyc(1);
        a1[1] = 99;
        chk("t3_al_A_c1", al_A[1], 20);
        cyc(1);
        chk("t3_al_A_c2", al_A[1], 20);
        cyc(1);
        chk("t3_al_A_c3", al_A[1], 20);
        chk("t3_no_ack_c3", DW'(ack1[1]), 0);
        cyc(1);
        chk("t3_ack1_c4", DW'(ack1[1]), 1);
        req1[1] = 1'b0;
        cyc(1);

        // Reset during BUSY: abort without ack, then retry completes normally.
        a0[1] = 9; b0[1] = 4; cmd0[1] = 2; req0[1] = 1'b1;
        push(1, 1'b0, 5);
        cyc(1);
        chk("t5_busy_c1", DW'(busy[1]), 1);
        rst[1] = 1'b1;
        cyc(1);
        rst[1] = 1'b0;
        chk("t5_rst_busy", DW'(busy[1]), 0);
        chk("t5_rst_al_A", al_A[1], 0);
        chk("t5_rst_al_B", al_B[1], 0);
        chk("t5_rst_al_cmd", DW'(al_cmd[1]), 0);
        chk("t5_rst_res", res[1], 0);
        chk("t5_rst_ack0", DW'(ack0[1]), 0);
        wait_ack(1, 1'b0, 20, n);
        chk("t5_retry_latency", n, 4);
        req0[1] = 1'b0;
        cyc(1);

        // New request raised during DONE is granted only from the following IDLE.
        a1[1] = 1000; b1[1] = 10; cmd1[1] = 3; req1[1] = 1'b1;
        push(1, 1'b1, 100); push(1, 1'b0, 6);
        wait_ack(1, 1'b1, 20, n);
        chk("t6_first_latency", n, 4);
        req1[1] = 1'b0;
        a0[1] = 3; b0[1] = 3; cmd0[1] = 1; req0[1] = 1'b1;
        cyc(1);
        chk("t6_idle_busy", DW'(busy[1]), 0);
        chk("t6_idle_al_A", al_A[1], 0);
        cyc(1);
        chk("t6_grant_al_A", al_A[1], 3);
        chk("t6_grant_busy", DW'(busy[1]), 1);
        wait_ack(1, 1'b0, 20, n);
        chk("t6_second_latency", n, 3);
        req0[1] = 1'b0;
        cyc(2);

        chk("sb_drained_inst0", q0.size(), 0);
        chk("sb_drained_inst1", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single calculator ALU between two requesters.
  - Requester 0: main controller (evaluate/append/backspace arithmetic).
  - Requester 1: output formatter (repeated divide-by-ten for digit extraction).
- Registers operands, holds them on the ALU for a fixed latency, captures the result and returns it with a one-cycle acknowledge.
- Round-robin arbitration, plus a per-requester lock for back-to-back multi-op sequences.

Parameters:
- DATA_W, 32: data operand/result width (matches data stack width).
- CMD_W, 3: ALU command width.
- ALU_LAT, 1: cycles operands are held on the ALU before al_C is captured; legal range 1..15.
- IDLE_CMD, 0: ALU command driven when no operation is in progress (NOP).

Ports:
- Clock  in  1  system clock, all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 operation request; held until ack0.
- a0  in  DATA_W  requester 0 operand A.
- b0  in  DATA_W  requester 0 operand B.
- cmd0  in  CMD_W  requester 0 ALU command.
- lock0  in  1  requester 0 keeps ownership after its ack.
- ack0  out  1  one-cycle pulse, result for requester 0 valid on res.
- req1, a1, b1, cmd1, lock1, ack1: same as requester 0, for requester 1.
- res  out  DATA_W  captured ALU result; valid when ack0 or ack1 is high, held until next capture.
- busy  out  1  high in BUSY and DONE.
- al_A  out  DATA_W  ALU operand A.
- al_B  out  DATA_W  ALU operand B.
- al_cmd  out  CMD_W  ALU command.
- al_C  in  DATA_W  ALU result (combinational from al_A/al_B/al_cmd).

Behaviour:
- Reset: state IDLE; al_A=0, al_B=0, al_cmd=IDLE_CMD; res=0; ack0=ack1=0; busy=0; last-grant pointer=1 (requester 0 wins the first tie); owner lock cleared.
- Reset wins over every other event. Reset mid-operation aborts with no ack, and the next cycle is a clean IDLE.
- All outputs are registered.

State machine:
- IDLE: arbitrate when req0 or req1 is high.
  - On the clock edge: latch the winner's a/b/cmd into al_A/al_B/al_cmd, record the grantee, load counter=ALU_LAT-1, go to BUSY.
- BUSY: al_A/al_B/al_cmd held constant. Counter decrements each cycle.
  - When counter==0: res<=al_C, assert the grantee's ack, al_A/al_B<=0, al_cmd<=IDLE_CMD, go to DONE.
- DONE: ack high for exactly this cycle. Requests are not sampled. Go to IDLE.

Timing:
- req asserted in IDLE cycle 0 -> ALU driven cycles 1..ALU_LAT -> ack and res valid in cycle ALU_LAT+1 -> IDLE in cycle ALU_LAT+2.
- Throughput: one op per ALU_LAT+2 cycles.

Arbitration:
- Only one requesting: it wins.
- Both requesting: the requester not granted last wins; the pointer updates on every grant.
- Lock: if the grantee's lock is high in DONE, ownership is retained. While owned, IDLE grants only the owner; the other requester waits even if the owner is idle. Ownership releases in the first IDLE cycle where the owner's lock is low; normal arbitration applies that same cycle.

Handshake rules:
- A requester holds req, a, b, cmd stable until its ack.
- Operands are sampled only at the grant edge; changes after the grant are ignored.
- Dropping req after the grant is a protocol violation. The operation completes and ack still pulses.
- A requester may re-assert req in the cycle after ack (IDLE) with no bubble beyond DONE.
- ack0 and ack1 are never high together; res changes only at capture.

Test Plan:
- ALU_LAT=1, adder cmd: req0 a0=5 b0=7 at cycle 0 -> al_A=5 al_B=7 in cycle 1; ack0=1 res=12 in cycle 2; busy low in cycle 3; al_cmd=IDLE_CMD from cycle 2.
- req0 and req1 both held continuously -> grants alternate 0,1,0,1; each ack pulse is one cycle; no cycle has both acks.
- ALU_LAT=3, a1 changed one cycle after the grant -> al_A stays at the granted value for 3 cycles; ack1 in cycle 4; res from the original operands.
- lock1=1 for 3 ops with req0 high throughout -> three consecutive ack1 before any ack0; ack0 follows once lock1 drops.
- Reset asserted in BUSY cycle 1 with ALU_LAT=3 -> no ack; next cycle all outputs at reset values; a following req0 completes normally with correct latency.
- DONE cycle with a new req already high -> not granted until IDLE; grant edge exactly one cycle after ack.
